// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with write-to-read bypass, optional hardwired zero register and busy scoreboard
// Ports: clk, rst (sync, active-high); we_i/wa_i/wd_i = NWR write ports; ra_i/rd_o/rbusy_o = NRD read ports;
//        set_en_i/set_a_i = mark a register busy; busy_all_o = registered scoreboard vector.
module register_file_mp #(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we_i,
  input  logic [NWR*ADDR-1:0]   wa_i,
  input  logic [NWR*DATA-1:0]   wd_i,
  input  logic [NRD*ADDR-1:0]   ra_i,
  output logic [NRD*DATA-1:0]   rd_o,
  output logic [NRD-1:0]        rbusy_o,
  input  logic                  set_en_i,
  input  logic [ADDR-1:0]       set_a_i,
  output logic [(1<<ADDR)-1:0]  busy_all_o
);
  localparam int DEPTH = 1 << ADDR;
  logic [DATA-1:0]  mem_q [DEPTH];
  logic [DATA-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  // Ports are applied in ascending order so the highest-numbered port wins; set is applied last so it beats a retiring clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++)
      if (we_i[k]) begin
        mem_d[wa_i[k*ADDR +: ADDR]]  = wd_i[k*DATA +: DATA];
        busy_d[wa_i[k*ADDR +: ADDR]] = 1'b0;
      end
    if (set_en_i) busy_d[set_a_i] = 1'b1;
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end
  assign busy_all_o = rst ? '0 : busy_q;
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR-1:0] a;
    logic            hit;
    logic [DATA-1:0] byp;
    logic            zero;
    assign a    = ra_i[j*ADDR +: ADDR];
    assign zero = (ZERO_REG != 0) && (a == '0);
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int k = 0; k < NWR; k++)
        if ((BYPASS != 0) && we_i[k] && (wa_i[k*ADDR +: ADDR] == a)) begin
          hit = 1'b1;
          byp = wd_i[k*DATA +: DATA];
        end
    end
    // A bypassed register is about to retire, so it only looks busy if a new producer claims it in the same cycle.
    assign rd_o[j*DATA +: DATA] = (rst || zero) ? '0 : hit ? byp : mem_q[a];
    assign rbusy_o[j]           = (rst || zero) ? 1'b0 : hit ? (set_en_i && set_a_i == a) : busy_q[a];
  end
endmodule
